// File: rtl/xbus_hub_pkg.sv
// Shared definitions for the xbus_hub interconnect: FSM states, bus error
// pattern, default status-register address and status word layout.
package xbus_hub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } xbus_state_e;

    localparam logic [31:0] BUS_ERR_DATA   = 32'hDEAD_BEEF;
    localparam logic [15:0] DEF_STAT_ADDR  = 16'h03F0;

    // Status word: error count in the upper half, last error address below.
    localparam int STAT_CNT_LSB  = 16;
    localparam int STAT_ADDR_LSB = 0;

    function automatic logic [31:0] stat_word(input logic [15:0] cnt,
                                              input logic [15:0] addr);
        logic [31:0] w;
        w = '0;
        w[STAT_CNT_LSB  +: 16] = cnt;
        w[STAT_ADDR_LSB +: 16] = addr;
        return w;
    endfunction

endpackage

// File: rtl/xbus_decode.sv
// Priority address decoder: status register first, then the lowest-numbered
// slot whose masked address equals its base, otherwise unmapped.
module xbus_decode
    import xbus_hub_pkg::*;
#(
    parameter int                        ADDR_W    = 10,
    parameter int                        N_SLV     = 8,
    parameter logic [N_SLV*ADDR_W-1:0]   BASES     = '0,
    parameter logic [N_SLV*ADDR_W-1:0]   MASKS     = '0,
    parameter logic [ADDR_W-1:0]         STAT_ADDR = DEF_STAT_ADDR[ADDR_W-1:0]
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [N_SLV-1:0]  slot_oh,
    output logic              stat_hit,
    output logic              unmapped
);

    // Walk slots from highest to lowest so the lowest match overwrites the rest.
    always_comb begin
        slot_oh  = '0;
        stat_hit = (addr == STAT_ADDR);
        if (!stat_hit) begin
            for (int i = N_SLV - 1; i >= 0; i--) begin
                if ((addr & MASKS[i*ADDR_W +: ADDR_W]) == BASES[i*ADDR_W +: ADDR_W]) begin
                    slot_oh    = '0;
                    slot_oh[i] = 1'b1;
                end
            end
        end
        unmapped = !stat_hit && (slot_oh == '0);
    end

endmodule

// File: rtl/xbus_hub.sv
// Registered, handshaked memory-mapped interconnect between the xctrl master
// and up to N_SLV peripherals, with bus timeout and an error status register.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for m_sel; latches request and decode result
//  ST_WAIT | slave selected, waiting for s_ready or timeout
//  ST_RESP | m_ack pulse with m_err/m_rdata, s_sel released
module xbus_hub
    import xbus_hub_pkg::*;
#(
    parameter int                        ADDR_W    = 10,
    parameter int                        DATA_W    = 32,
    parameter int                        N_SLV     = 8,
    parameter logic [N_SLV*ADDR_W-1:0]   BASES     = '0,
    parameter logic [N_SLV*ADDR_W-1:0]   MASKS     = '0,
    parameter logic [ADDR_W-1:0]         STAT_ADDR = DEF_STAT_ADDR[ADDR_W-1:0],
    parameter int                        TIMEOUT   = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      m_sel,
    input  logic                      m_we,
    input  logic [ADDR_W-1:0]         m_addr,
    input  logic [DATA_W-1:0]         m_wdata,
    output logic [DATA_W-1:0]         m_rdata,
    output logic                      m_ack,
    output logic                      m_err,
    output logic [N_SLV-1:0]          s_sel,
    output logic                      s_we,
    output logic [ADDR_W-1:0]         s_addr,
    output logic [DATA_W-1:0]         s_wdata,
    input  logic [N_SLV*DATA_W-1:0]   s_rdata,
    input  logic [N_SLV-1:0]          s_ready,
    output logic                      irq_err
);

    localparam int              TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TLOAD = TW'(TIMEOUT - 1);

    xbus_state_e         state_q, state_d;
    logic [N_SLV-1:0]    sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [TW-1:0]       tcnt_q, tcnt_d;
    logic                ack_q, ack_d;
    logic                err_q, err_d;
    logic                irq_q, irq_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   last_err_q, last_err_d;

    logic [N_SLV-1:0]    dec_oh;
    logic                dec_stat;
    logic                dec_unmapped;
    logic [DATA_W-1:0]   slv_rdata;
    logic                slv_ready;
    logic                err_event;
    logic [ADDR_W-1:0]   err_addr;

    xbus_decode #(
        .ADDR_W    (ADDR_W),
        .N_SLV     (N_SLV),
        .BASES     (BASES),
        .MASKS     (MASKS),
        .STAT_ADDR (STAT_ADDR)
    ) u_decode (
        .addr     (m_addr),
        .slot_oh  (dec_oh),
        .stat_hit (dec_stat),
        .unmapped (dec_unmapped)
    );

    // One-hot read-data mux and ready qualifier for the selected slot only.
    always_comb begin
        slv_rdata = '0;
        for (int i = 0; i < N_SLV; i++) begin
            if (sel_q[i]) slv_rdata = slv_rdata | s_rdata[i*DATA_W +: DATA_W];
        end
        slv_ready = |(sel_q & s_ready);
    end

    // Next-state logic for the transaction FSM, response and error bookkeeping.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tcnt_d     = tcnt_q;
        ack_d      = 1'b0;
        err_d      = 1'b0;
        irq_d      = 1'b0;
        rdata_d    = rdata_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;
        err_event  = 1'b0;
        err_addr   = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (m_sel) begin
                    we_d    = m_we;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    if (dec_stat) begin
                        state_d = ST_RESP;
                        ack_d   = 1'b1;
                        if (m_we) begin
                            rdata_d    = '0;
                            err_cnt_d  = '0;
                            last_err_d = '0;
                        end else begin
                            rdata_d = DATA_W'(stat_word(err_cnt_q, 16'(last_err_q)));
                        end
                    end else if (dec_unmapped) begin
                        state_d   = ST_RESP;
                        ack_d     = 1'b1;
                        err_d     = 1'b1;
                        rdata_d   = '0;
                        err_event = 1'b1;
                        err_addr  = m_addr;
                    end else begin
                        state_d = ST_WAIT;
                        sel_d   = dec_oh;
                        tcnt_d  = TLOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (slv_ready) begin
                    state_d = ST_RESP;
                    sel_d   = '0;
                    ack_d   = 1'b1;
                    rdata_d = we_q ? '0 : slv_rdata;
                end else if (tcnt_q == '0) begin
                    state_d   = ST_RESP;
                    sel_d     = '0;
                    ack_d     = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = DATA_W'(BUS_ERR_DATA);
                    err_event = 1'b1;
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
        if (err_event) begin
            irq_d      = 1'b1;
            last_err_d = err_addr;
            if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    // State and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tcnt_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tcnt_q     <= tcnt_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
        end
    end

    assign s_sel   = sel_q;
    assign s_we    = we_q;
    assign s_addr  = addr_q;
    assign s_wdata = wdata_q;
    assign m_ack   = ack_q;
    assign m_err   = err_q;
    assign m_rdata = rdata_q;
    assign irq_err = irq_q;

endmodule

// File: doc/xbus_hub.md
# xbus_hub

Parametrised memory-mapped I/O interconnect between the `xctrl` data bus and up to `N_SLV` peripherals (register file, PS/2, display, LEDs, switches, ...). It replaces a purely combinational address decoder with a registered, handshaked transaction engine:

- per-slot base/mask decode with fixed priority;
- slave back-pressure via per-slot ready;
- a bus timeout;
- an internal status register that counts and records unmapped and timed-out accesses.

## Interface
Parameters:
- `ADDR_W`, 10, bus address width (≤ 16)
- `DATA_W`, 32, bus data width (≥ 32)
- `N_SLV`, 8, number of peripheral slots (1..16)
- `BASES`, 0, packed `N_SLV*ADDR_W` slot base addresses; slot i = bits `[i*ADDR_W +: ADDR_W]`
- `MASKS`, 0, packed `N_SLV*ADDR_W` slot match masks, same layout
- `STAT_ADDR`, 10'h3F0, address of the internal status register
- `TIMEOUT`, 16, maximum WAIT cycles before a bus error (≥ 1)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `m_sel`  in  1  master request
- `m_we`  in  1  master write enable
- `m_addr`  in  `ADDR_W`  master address
- `m_wdata`  in  `DATA_W`  master write data
- `m_rdata`  out  `DATA_W`  read data, valid when `m_ack`
- `m_ack`  out  1  one-cycle transaction-complete pulse
- `m_err`  out  1  error qualifier, valid with `m_ack`
- `s_sel`  out  `N_SLV`  one-hot slave select
- `s_we`  out  1  slave write enable
- `s_addr`  out  `ADDR_W`  registered address
- `s_wdata`  out  `DATA_W`  registered write data
- `s_rdata`  in  `N_SLV*DATA_W`  packed slave read data
- `s_ready`  in  `N_SLV`  per-slot completion
- `irq_err`  out  1  one-cycle pulse on every error response

## Operation
- Decode:
  - `m_addr == STAT_ADDR` selects the status register first.
  - Otherwise the lowest i with `(m_addr & MASK_i) == BASE_i` is selected.
  - No match: unmapped.
- FSM states: `IDLE`, `WAIT`, `RESP`.
- `IDLE`: when `m_sel=1`, latch `m_we`/`m_addr`/`m_wdata` and the decode result.
  - Mapped slot → `WAIT`; `s_sel[k]` is driven from the register.
  - Status or unmapped → `RESP` directly.
- `WAIT`: `s_sel[k]`, `s_we`, `s_addr` and `s_wdata` are held stable.
  - `s_ready[k]=1`: capture `s_rdata[k]` (reads) and go to `RESP`, no error.
  - `s_ready[k]=0` on the `TIMEOUT`-th `WAIT` cycle: go to `RESP` with error; `m_rdata = 32'hDEAD_BEEF` zero-extended.
  - `s_ready` on the last allowed cycle wins over the timeout.
- `RESP`: `m_ack=1` for one cycle with `m_err` and `m_rdata`, then `IDLE`. `s_sel` is 0.
- Unmapped access: `m_err=1`, `m_rdata=0`; writes are dropped.
- Status read returns `{err_cnt[15:0], last_err_addr zero-extended to 16 bits}` in bits [31:0]; upper bits are 0.
- Status write (any data) clears `err_cnt` and `last_err_addr`. The access itself is not an error.
- Every error response:
  - `err_cnt` increments, saturating at 16'hFFFF;
  - `last_err_addr` ← the latched address;
  - `irq_err` pulses in the same cycle as `m_ack`.
- `s_ready` from non-selected slots is ignored. `m_sel` is ignored outside `IDLE`.
- The master holds its request until `m_ack`. Re-asserting `m_sel` in the cycle after `m_ack` starts a new transaction.

## Timing
- Reset (`rst=0`, asynchronous):
  - state `IDLE`;
  - `s_sel`, `s_we`, `s_addr`, `s_wdata` = 0;
  - `m_ack`, `m_err`, `irq_err`, `m_rdata` = 0;
  - `err_cnt`, `last_err_addr` = 0.
- Reset mid-transaction aborts with no ack; `s_sel` drops immediately.
- Cycle 0 is `m_sel` sampled in `IDLE`.
  - Slave access: `s_sel` valid from cycle 1. `s_ready` sampled in cycle n (n ≥ 1) gives `m_ack` in cycle n+1.
  - Minimum slave latency is 2 cycles.
  - Timeout: `m_ack`+`m_err` in cycle `TIMEOUT`+1.
  - Status or unmapped: `m_ack` in cycle 1.
- Back-to-back throughput: one transaction per latency+1 cycles.
- All outputs are registered; there are no combinational paths from master inputs to master outputs.

## Structure
- Shared package/defines header `xbusdefs.vh`:
  - FSM state encodings;
  - `BUS_ERR_DATA` (32'hDEAD_BEEF);
  - default `STAT_ADDR`;
  - status field offsets.
- Sub-module `xbus_decode`: combinational priority decoder from address to one-hot slot, status hit and unmapped flag; reusable in the top-level wiring.
- Timeout counter width is `$clog2(TIMEOUT+1)`.

## Test plan
- Slot 2 with base 10'h030 and mask 10'h3F0, `s_ready` tied high; read 10'h031 with `s_rdata[2]=32'h1234` → `s_sel=3'b100`-bit-2 in cycle 1, `m_ack` cycle 2, `m_rdata=32'h1234`, `m_err=0`.
- Overlapping slots 0 and 1 both match 10'h040 → only `s_sel[0]` asserts.
- Write to slot 3 with `s_ready` delayed 5 cycles → `s_we`/`s_wdata` stable cycles 1–5, `m_ack` cycle 6.
- `TIMEOUT=4`, slot never ready → `m_ack`+`m_err`+`irq_err` in cycle 5, `m_rdata=32'hDEADBEEF`; status read returns `{16'd1, addr}`.
- Unmapped read ×3, then status read → 32'h0003_xxxx with the last address; status write, then status read → 0.
- Assert `rst=0` during `WAIT` → `s_sel` drops asynchronously, no `m_ack`; the next transaction completes normally.
